// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_e;
`endif

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 3;

  localparam int CTL_FLUSH   = 0;
  localparam int CTL_CLR_OVF = 1;

  localparam int         FIFO_DEPTH = 4;
  localparam logic [2:0] LAST_BIT   = 3'd7;

  function automatic logic [7:0] pack_status(input logic [2:0] count, input logic ovf,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s                     = '0;
    s[STAT_FULL]          = full;
    s[STAT_EMPTY]         = empty;
    s[STAT_OVF]           = ovf;
    s[STAT_CNT_LSB +: 3]  = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// 4x8 synchronous FIFO: flush beats push, simultaneous push/pop works even when
// full, pop of an empty FIFO is ignored.
module fifo_sync4
  import uart_tx_pkg::*;
(
  input  logic       nclk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_do_pop;
  logic       w_do_push;

  assign empty     = (r_count == 3'd0);
  assign full      = (r_count == 3'(FIFO_DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & ~flush & (~full | w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + 3'(w_do_push) - 3'(w_do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge nclk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-slave 8N1 UART transmitter with DATA/STATUS/DIV registers and 4-byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter logic [7:0]  DIV_RESET = 8'd103
) (
  input  logic        nclk,
  input  logic        rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        oe,
  input  logic        we,
  output logic        tx,
  output logic        tx_busy
);

  logic       w_sel;
  logic [1:0] w_ofs;
  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_rdata;
  logic       w_push;
  logic       w_flush;
  logic       w_clr_ovf;
  logic       w_ovf_set;
  logic [7:0] w_dout;
  logic [2:0] w_count;
  logic       w_full;
  logic       w_empty;

  logic [7:0] r_div;
  logic       r_ovf;
  tx_state_e  r_state;
  tx_state_e  w_next_state;
  logic [7:0] r_baud_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic       r_tx;
  logic       w_tick;
  logic       w_pop;
  logic       w_load;
  logic       w_shift_en;
  logic       w_boundary;
  logic       w_tx_next;
`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`endif

  // Bus decode: a write cycle wins over a read, so d is never driven then.
  assign w_sel     = (a[15:2] == BASE[15:2]);
  assign w_ofs     = a[1:0];
  assign w_wr      = w_sel & ~we;
  assign w_rd      = w_sel & ~oe & we;
  assign w_push    = w_wr & (w_ofs == OFS_DATA);
  assign w_flush   = w_wr & (w_ofs == OFS_STATUS) & d[CTL_FLUSH];
  assign w_clr_ovf = w_wr & (w_ofs == OFS_STATUS) & d[CTL_CLR_OVF];
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_comb begin
    w_rdata = 8'h00;
    case (w_ofs)
      OFS_STATUS: w_rdata = pack_status(w_count, r_ovf, w_empty, w_full);
      OFS_DIV:    w_rdata = r_div;
      default:    w_rdata = 8'h00;
    endcase
  end

  assign d = w_rd ? w_rdata : 8'bz;

  fifo_sync4 u_fifo (
    .nclk  (nclk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (d),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && w_ofs == OFS_DIV) r_div <= d;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign w_tick = (r_baud_cnt == 8'd0);

  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_shift_en   = 1'b0;
    w_boundary   = 1'b0;
    w_tx_next    = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_next_state = ST_START;
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_boundary   = 1'b1;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_next_state = ST_DATA;
          w_boundary   = 1'b1;
          w_tx_next    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_boundary = 1'b1;
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_next_state = ST_PARITY;
            w_tx_next    = r_parity;
`else
            w_next_state = ST_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_shift_en = 1'b1;
            w_tx_next  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_next_state = ST_STOP;
          w_boundary   = 1'b1;
          w_tx_next    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_boundary = 1'b1;
          if (!w_empty) begin
            w_next_state = ST_START;
            w_pop        = 1'b1;
            w_load       = 1'b1;
            w_tx_next    = 1'b0;
          end else begin
            w_next_state = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // The baud counter reloads from the live divider only at bit boundaries.
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_next;
      if (w_boundary)     r_baud_cnt <= r_div;
      else if (!w_tick)   r_baud_cnt <= r_baud_cnt - 8'd1;
      if (w_load) begin
        r_shift   <= w_dout;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^w_dout;
`endif
      end else if (w_shift_en) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped serial transmitter hanging off the CPU's external address/data bus (a, d, oe, we), on the same side as RAM/ROM. It decodes a 4-byte window, accepts bytes into a 4-entry FIFO, and shifts them out as 8N1 asynchronous serial, LSB first. Status is readable so firmware can poll for space. It is a bus slave only: it never drives a, oe or we.

## Interface
Parameters:
- BASE, 16'hFF00, window base address; must be 4-byte aligned.
- DIV_RESET, 8'd103, baud divider value loaded at reset.

Ports:
- nclk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- a  in  16  CPU address bus.
- d  inout  8  CPU data bus; driven only during a decoded read, high-Z otherwise.
- oe  in  1  read strobe, active-low.
- we  in  1  write strobe, active-low.
- tx  out  1  serial output; idle/mark level is 1.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Decode: `sel = (a[15:2] == BASE[15:2])`. Offset is a[1:0].
- Offset 0 DATA:
  - Write pushes d into the FIFO.
  - Read returns 8'h00.
- Offset 1 STATUS:
  - Read returns {2'b0, count[2:0], ovf, empty, full}.
  - Write: bit0=1 flushes the FIFO; bit1=1 clears ovf.
- Offset 2 DIV:
  - Read and write the baud divider.
  - A new value takes effect at the next bit boundary.
- Offset 3: reserved. Reads return 8'h00; writes are ignored.
- Write commit: on rising nclk when sel & ~we. If oe and we are both low, the write wins and d is not driven.
- Read drive: combinational. d = register value when sel & ~oe & we, else 8'bz.
- FIFO: 4 entries, count 0..4.
  - Push when full: byte dropped, ovf set (sticky).
  - Push and pop in the same cycle: both happen, count unchanged, including when full. No ovf in that case.
  - Flush and push in the same cycle: flush wins, push discarded.
- Transmit FSM states: IDLE, START, DATA, PARITY (compiled-in only), STOP.
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register on that edge.
  - START → DATA, DATA (bit 0..7) → STOP, STOP → START if the FIFO is non-empty, else IDLE.
  - Each state/bit lasts DIV+1 nclk cycles, timed by a down-counter reloaded at every bit boundary.
  - DIV=0 gives 1 cycle per bit.
- tx level per state: IDLE=1, START=0, DATA=shift[0] (shift right), STOP=1.
- A flush during a frame does not abort it; only the queued bytes are discarded.

## Timing
- Reset values: tx=1, tx_busy=0, state=IDLE, count=0, ovf=0, DIV=DIV_RESET, d=high-Z.
- rst low mid-frame forces tx=1 immediately (asynchronous); the frame is lost.
- Latency: a DATA write at edge k with IDLE and an empty FIFO gives tx=0 from edge k+1.
- Frame length: 10×(DIV+1) cycles without parity, 11×(DIV+1) with parity.
- Back-to-back frames: the next START begins on the edge that ends STOP, with no idle gap.
- STATUS reflects state after the most recent edge. A read in the same cycle as a write returns the pre-write value.
- tx is registered and glitch-free.

## Configuration
- UART_TX_PARITY_EN defined:
  - The PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits).
  - Frame is 11 bit-times.
- UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent; frame is 10 bit-times.

## Structure
- Package uart_tx_pkg holds:
  - The state enum.
  - Offset constants OFS_DATA=2'd0, OFS_STATUS=2'd1, OFS_DIV=2'd2.
  - STATUS bit index constants.
- Sub-module fifo_sync4: 4×8 synchronous FIFO.
  - Ports: push, pop, flush, din, dout, count, full, empty, with the push/pop/flush priority described in Operation.
  - Pop of an empty FIFO is ignored.
- Top level holds the decoder, register file, baud counter and FSM.

## Test plan
- Reset: rst low → tx=1, d=Z. Read STATUS → 8'h02 (empty). Read DIV → 8'd103.
- Single byte: write DIV=0, write DATA=8'hA5 at edge k.
  - tx from edge k+1 across 10 cycles: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy drops after the STOP cycle.
- Overflow: DIV=3, write 6 bytes back-to-back starting idle.
  - The first is popped immediately, the next 4 fill the FIFO.
  - The 6th is dropped: STATUS = full=1, ovf=1, count=4.
  - Write STATUS=8'h02 clears ovf.
- Flush mid-frame: 3 queued bytes, flush during DATA of byte 1.
  - Byte 1 completes.
  - tx stays 1 afterwards.
  - STATUS reads 8'h02.
- Reset mid-frame: drop rst during DATA → tx=1 the same instant; count=0 after release.
- Parity (UART_TX_PARITY_EN): DIV=0, DATA=8'h07 → parity bit = 1 at the 10th bit-time, STOP at the 11th.
